// File: rtl/game_screen_seq.sv
// Frame-based screen sequencer: TITLE -> COUNTDOWN -> PLAY -> GAMEOVER -> TITLE.
// Optional PLAY pause support is compiled in with `define GAME_SCREEN_PAUSE_EN.
module game_screen_seq #(
   parameter int FRAMES_PER_SEC  = 60,
   parameter int COUNT_START     = 3,
   parameter int BLINK_FRAMES    = 30,
   parameter int GAMEOVER_FRAMES = 180
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       start_btn,
   input  logic       player_dead,
   input  logic       pause_btn,
   output logic [1:0] screen,
   output logic [2:0] timer,
   output logic [3:0] text_on,
   output logic       game_run,
   output logic       frame_tick
);

   localparam int MAX_A  = (FRAMES_PER_SEC > BLINK_FRAMES) ? FRAMES_PER_SEC : BLINK_FRAMES;
   localparam int MAX_F  = (MAX_A > GAMEOVER_FRAMES) ? MAX_A : GAMEOVER_FRAMES;
   localparam int CW     = (MAX_F > 1) ? $clog2(MAX_F) : 1;

   localparam logic [CW-1:0] FPS_LAST   = CW'(FRAMES_PER_SEC - 1);
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
   localparam logic [CW-1:0] GO_LAST    = CW'(GAMEOVER_FRAMES - 1);
   localparam logic [2:0]    COUNT_INIT = 3'(COUNT_START);

   typedef enum logic [1:0] {
      S_TITLE     = 2'd0,
      S_COUNTDOWN = 2'd1,
      S_PLAY      = 2'd2,
      S_GAMEOVER  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      timer_q, timer_d;
   logic            blink_q, blink_d;
   logic [3:0]      text_on_q, text_on_d;
   logic            game_run_q, game_run_d;
   logic            vsync_q, frame_tick_q;
   logic            start_s1_q, start_s2_q, start_prev_q;
   logic            start_pulse;
   logic            paused_q, paused_d;

   assign start_pulse = start_s2_q & ~start_prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_TITLE;
         cnt_q        <= '0;
         timer_q      <= 3'd0;
         blink_q      <= 1'b1;
         text_on_q    <= 4'b0001;
         game_run_q   <= 1'b0;
         vsync_q      <= 1'b1;
         frame_tick_q <= 1'b0;
         start_s1_q   <= 1'b0;
         start_s2_q   <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         blink_q      <= blink_d;
         text_on_q    <= text_on_d;
         game_run_q   <= game_run_d;
         vsync_q      <= vsync;
         frame_tick_q <= vsync_q & ~vsync;
         start_s1_q   <= start_btn;
         start_s2_q   <= start_s1_q;
         start_prev_q <= start_s2_q;
      end
   end

`ifdef GAME_SCREEN_PAUSE_EN
   logic pause_s1_q, pause_s2_q, pause_prev_q;
   logic pause_pulse;

   assign pause_pulse = pause_s2_q & ~pause_prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pause_s1_q   <= 1'b0;
         pause_s2_q   <= 1'b0;
         pause_prev_q <= 1'b0;
         paused_q     <= 1'b0;
      end else begin
         pause_s1_q   <= pause_btn;
         pause_s2_q   <= pause_s1_q;
         pause_prev_q <= pause_s2_q;
         paused_q     <= paused_d;
      end
   end

   // Paused only survives while PLAY is both the current and next screen.
   always_comb begin
      paused_d = paused_q;
      if (state_q != S_PLAY || state_d != S_PLAY) begin
         paused_d = 1'b0;
      end else if (pause_pulse) begin
         paused_d = ~paused_q;
      end
   end
`else
   logic unused_pause_btn;
   assign unused_pause_btn = pause_btn;
   assign paused_q         = 1'b0;
   assign paused_d         = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      blink_d = blink_q;
      case (state_q)
         S_TITLE: begin
            if (start_pulse) begin
               state_d = S_COUNTDOWN;
               timer_d = COUNT_INIT;
               cnt_d   = '0;
            end else if (frame_tick_q) begin
               if (cnt_q == BLINK_LAST) begin
                  cnt_d   = '0;
                  blink_d = ~blink_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_COUNTDOWN: begin
            if (frame_tick_q) begin
               if (cnt_q == FPS_LAST) begin
                  cnt_d = '0;
                  if (timer_q > 3'd1) begin
                     timer_d = timer_q - 3'd1;
                  end else begin
                     timer_d = 3'd0;
                     state_d = S_PLAY;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_PLAY: begin
            // Death wins over any frame activity; a paused game cannot die.
            if (player_dead && !paused_q) begin
               state_d = S_GAMEOVER;
               cnt_d   = '0;
               timer_d = 3'd0;
            end
         end
         S_GAMEOVER: begin
            timer_d = 3'd0;
            if (start_pulse || (frame_tick_q && cnt_q == GO_LAST)) begin
               state_d = S_TITLE;
               cnt_d   = '0;
               blink_d = 1'b1;
            end else if (frame_tick_q) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_TITLE;
            cnt_d   = '0;
            timer_d = 3'd0;
            blink_d = 1'b1;
         end
      endcase
   end

   // Outputs decode from the next state so they register alongside it.
   always_comb begin
      text_on_d  = 4'b0001;
      game_run_d = 1'b0;
      case (state_d)
         S_TITLE:     text_on_d = {3'b000, blink_d};
         S_COUNTDOWN: text_on_d = 4'b0010;
         S_PLAY: begin
            if (paused_d) begin
               text_on_d = 4'b0101;
            end else begin
               text_on_d  = 4'b0100;
               game_run_d = 1'b1;
            end
         end
         S_GAMEOVER:  text_on_d = 4'b1000;
         default:     text_on_d = 4'b0001;
      endcase
   end

   assign screen     = state_q;
   assign timer      = timer_q;
   assign text_on    = text_on_q;
   assign game_run   = game_run_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_game_screen_seq.sv
// Self-checking bench for game_screen_seq: frame-count reference model plus directed scenarios.
module tb_game_screen_seq;

   localparam int FPS = 4;
   localparam int CS  = 3;
   localparam int BF  = 2;
   localparam int GOF = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vsync = 1'b1;
   logic       start_btn = 1'b0;
   logic       player_dead = 1'b0;
   logic       pause_btn = 1'b0;
   logic [1:0] screen;
   logic [2:0] timer;
   logic [3:0] text_on;
   logic       game_run;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;
   int vcnt = 0;
   int cd_ticks = 0;
   int go_ticks = 0;

   // Reference model: screen plus frames elapsed since entering it.
   int   m_scr = 0;
   int   m_frames = 0;
   bit   m_paused = 1'b0;
   bit   m_tick = 1'b0;
   bit   m_vprev = 1'b1;
   bit   m_valid = 1'b0;
   bit   s_hist [3] = '{1'b0, 1'b0, 1'b0};
   bit   p_hist [3] = '{1'b0, 1'b0, 1'b0};

   game_screen_seq #(
      .FRAMES_PER_SEC (FPS),
      .COUNT_START    (CS),
      .BLINK_FRAMES   (BF),
      .GAMEOVER_FRAMES(GOF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .start_btn  (start_btn),
      .player_dead(player_dead),
      .pause_btn  (pause_btn),
      .screen     (screen),
      .timer      (timer),
      .text_on    (text_on),
      .game_run   (game_run),
      .frame_tick (frame_tick)
   );

   // Clock and reset-time drivers
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         vcnt  = (vcnt + 1) % 20;
         vsync = (vcnt < 2) ? 1'b0 : 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not seen within budget at %0t", name, $time);
   endtask

   function automatic int exp_timer();
      return (m_scr == 1) ? (CS - m_frames / FPS) : 0;
   endfunction

   function automatic int exp_text();
      case (m_scr)
         0:       return ((m_frames / BF) % 2 == 0) ? 1 : 0;
         1:       return 2;
         2:       return m_paused ? 5 : 4;
         default: return 8;
      endcase
   endfunction

   // Model update on every rising edge, from the inputs seen at that edge
   always @(posedge clk) begin : model
      bit tick, sp, pp;
      tick = m_tick;
      sp   = s_hist[1] & ~s_hist[2];
      pp   = p_hist[1] & ~p_hist[2];
      if (reset) begin
         m_scr    = 0;
         m_frames = 0;
         m_paused = 1'b0;
         m_tick   = 1'b0;
         m_vprev  = 1'b1;
         s_hist   = '{1'b0, 1'b0, 1'b0};
         p_hist   = '{1'b0, 1'b0, 1'b0};
         m_valid  = 1'b1;
      end else begin
         case (m_scr)
            0: begin
               if (sp) begin
                  m_scr = 1; m_frames = 0;
               end else if (tick) begin
                  m_frames++;
               end
            end
            1: begin
               if (tick) begin
                  m_frames++;
                  if (m_frames == CS * FPS) begin
                     m_scr = 2; m_frames = 0;
                  end
               end
            end
            2: begin
               if (player_dead && !m_paused) begin
                  m_scr = 3; m_frames = 0; m_paused = 1'b0;
               end
`ifdef GAME_SCREEN_PAUSE_EN
               else if (pp) begin
                  m_paused = !m_paused;
               end
`endif
            end
            default: begin
               if (sp) begin
                  m_scr = 0; m_frames = 0;
               end else if (tick) begin
                  m_frames++;
                  if (m_frames == GOF) begin
                     m_scr = 0; m_frames = 0;
                  end
               end
            end
         endcase
         m_tick    = m_vprev & ~vsync;
         m_vprev   = vsync;
         s_hist[2] = s_hist[1]; s_hist[1] = s_hist[0]; s_hist[0] = start_btn;
         p_hist[2] = p_hist[1]; p_hist[1] = p_hist[0]; p_hist[0] = pause_btn;
      end
   end

   // Scoreboard compare on every falling edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("screen", int'(screen), m_scr);
         check("timer", int'(timer), exp_timer());
         check("text_on", int'(text_on), exp_text());
         check("game_run", int'(game_run), (m_scr == 2 && !m_paused) ? 1 : 0);
         check("frame_tick", int'(frame_tick), int'(m_tick));
      end
   end

   always @(negedge clk) begin
      if (screen == 2'd1 && frame_tick) cd_ticks++;
      if (screen == 2'd3 && frame_tick) go_ticks++;
   end

   // Must be called at a falling edge; returns at the falling edge where screen matches.
   task automatic wait_screen(input int s, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (int'(screen) == s) return;
         @(negedge clk);
      end
      timeout_fail(name);
   endtask

   task automatic press(input int len);
      start_btn = 1'b1;
      repeat (len) @(negedge clk);
      start_btn = 1'b0;
   endtask

   task automatic goto_play();
      press(3);
      wait_screen(1, 20, "to_countdown");
      wait_screen(2, 400, "to_play");
   endtask

   initial begin
      int s_left, p_left;
      bit hit;
      s_left = 0;
      p_left = 0;

      repeat (3) @(negedge clk);
      check("rst_screen", int'(screen), 0);
      check("rst_timer", int'(timer), 0);
      check("rst_text_on", int'(text_on), 1);
      check("rst_game_run", int'(game_run), 0);
      check("rst_frame_tick", int'(frame_tick), 0);
      reset = 1'b0;

      repeat (100) @(negedge clk);

      // Held start: single countdown, 12 frames to PLAY
      cd_ticks = 0;
      press(50);
      check("hold_screen", int'(screen), 1);
      check("hold_timer", int'(timer), 3);
      wait_screen(2, 400, "countdown_to_play");
      check("cd_frames", cd_ticks, 12);
      check("play_timer", int'(timer), 0);
      check("play_run", int'(game_run), 1);
      check("play_text", int'(text_on), 4);

      // Death on a frame_tick cycle
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) timeout_fail("tick_in_play");
      go_ticks = 0;
      player_dead = 1'b1;
      @(negedge clk);
      player_dead = 1'b0;
      check("dead_screen", int'(screen), 3);
      check("dead_run", int'(game_run), 0);
      check("dead_text", int'(text_on), 8);
      wait_screen(0, 300, "gameover_timeout");
      check("go_frames", go_ticks, GOF);
      check("go_back_blink", int'(text_on[0]), 1);

      // Start press in GAMEOVER returns to TITLE only
      goto_play();
      player_dead = 1'b1;
      @(negedge clk);
      player_dead = 1'b0;
      wait_screen(3, 10, "to_gameover");
      go_ticks = 0;
      for (int i = 0; i < 100 && go_ticks < 2; i++) @(negedge clk);
      if (go_ticks < 2) timeout_fail("go_two_frames");
      @(negedge clk);
      start_btn = 1'b1;
      repeat (3) @(negedge clk);
      check("go_start_screen", int'(screen), 0);
      repeat (3) @(negedge clk);
      start_btn = 1'b0;
      repeat (60) @(negedge clk);
      check("no_countdown", int'(screen), 0);

      // Reset held two cycles mid-PLAY
      goto_play();
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_screen", int'(screen), 0);
      check("mid_rst_timer", int'(timer), 0);
      check("mid_rst_text", int'(text_on), 1);
      check("mid_rst_run", int'(game_run), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);

`ifdef GAME_SCREEN_PAUSE_EN
      goto_play();
      pause_btn = 1'b1;
      repeat (4) @(negedge clk);
      pause_btn = 1'b0;
      check("pause_run", int'(game_run), 0);
      check("pause_text", int'(text_on), 5);
      player_dead = 1'b1;
      repeat (10) @(negedge clk);
      player_dead = 1'b0;
      check("pause_no_death", int'(screen), 2);
      pause_btn = 1'b1;
      repeat (4) @(negedge clk);
      pause_btn = 1'b0;
      check("resume_run", int'(game_run), 1);
      check("resume_text", int'(text_on), 4);
      player_dead = 1'b1;
      @(negedge clk);
      player_dead = 1'b0;
      repeat (5) @(negedge clk);
`endif

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (s_left > 0) begin
            s_left--;
         end else begin
            start_btn = 1'b0;
            if ($urandom_range(0, 40) == 0) begin
               start_btn = 1'b1;
               s_left = $urandom_range(1, 40);
            end
         end
         if (p_left > 0) begin
            p_left--;
         end else begin
            pause_btn = 1'b0;
            if ($urandom_range(0, 30) == 0) begin
               pause_btn = 1'b1;
               p_left = $urandom_range(1, 10);
            end
         end
         player_dead = ($urandom_range(0, 99) < 2);
         reset = ($urandom_range(0, 799) == 0);
      end
      reset = 1'b0;
      start_btn = 1'b0;
      pause_btn = 1'b0;
      player_dead = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_screen_seq.md
Name: game_screen_seq

Overview:
- Frame-based screen sequencer for the VGA game display.
- Tracks the active screen: TITLE, COUNTDOWN, PLAY, GAMEOVER.
- Drives the 3-bit countdown `timer` and the 4-bit `text_on` layer enables consumed by the text overlay generator.
- Drives `game_run`, which gates the game renderer/logic.
- Sits between the display timing generator (`vsync`) and the text/game pixel mux.

Parameters:
- FRAMES_PER_SEC, 60, frames per countdown step.
- COUNT_START, 3, initial countdown value; range 1..7.
- BLINK_FRAMES, 30, frames per half-period of the title blink.
- GAMEOVER_FRAMES, 180, frames GAMEOVER is held before auto-return to TITLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  vertical sync from the display timing generator, active-low pulse.
- start_btn  in  1  raw start button, asynchronous to clk.
- player_dead  in  1  level-sensitive, from game logic.
- pause_btn  in  1  raw pause button; used only when PAUSE_EN is defined.
- screen  out  2  0=TITLE, 1=COUNTDOWN, 2=PLAY, 3=GAMEOVER.
- timer  out  3  countdown value for the text overlay.
- text_on  out  4  one-hot text layer enables: [0] title, [1] countdown, [2] HUD, [3] game over.
- game_run  out  1  high only while gameplay advances.
- frame_tick  out  1  one-clk pulse per frame.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - screen=0 (TITLE), timer=0, text_on=4'b0001, game_run=0, frame_tick=0.
  - All counters 0; blink phase=1; synchronizer flops 0; vsync history flop 1.
- frame_tick:
  - vsync registered once; frame_tick=1 for exactly one clk when the registered value is 1 and the current vsync is 0 (falling edge).
  - 1-cycle latency from the vsync falling edge.
- start_btn path:
  - 2-flop synchronizer, then rising-edge detect giving start_pulse (1 clk).
  - Latency 3 clk from the input edge to action.
  - A held button produces one pulse only.
- frame_cnt:
  - Width = clog2 of the maximum of the three frame parameters.
  - Increments only on frame_tick and clears on every state transition.
  - A terminal count T means "frame_cnt==T-1 and frame_tick"; the counter clears on that tick.
- TITLE:
  - text_on[0]=blink; blink toggles at BLINK_FRAMES terminal count.
  - start_pulse: go to COUNTDOWN, timer<=COUNT_START, frame_cnt<=0.
- COUNTDOWN:
  - text_on=4'b0010.
  - At FRAMES_PER_SEC terminal count: if timer>1, timer<=timer-1; if timer==1, timer<=0 and go to PLAY.
  - start_pulse is ignored.
- PLAY:
  - text_on=4'b0100, game_run=1.
  - player_dead=1 goes to GAMEOVER next clk, with game_run=0 in the same cycle as screen=3.
- GAMEOVER:
  - text_on=4'b1000, timer=0.
  - Go to TITLE at GAMEOVER_FRAMES terminal count, or on start_pulse, whichever comes first.
  - On entry to TITLE, blink phase is forced to 1.
- Simultaneous events:
  - player_dead beats frame_tick.
  - In GAMEOVER, start_pulse and terminal count in the same cycle give a single transition to TITLE.
  - In COUNTDOWN, player_dead is ignored.
- Output timing: all outputs are registered; screen, text_on and game_run change in the same clk as the state register.
- Reset mid-operation: returns to TITLE in one clk with all reset values, regardless of state or counter values.
- No arithmetic wrap: timer never decrements below 0, and frame_cnt never exceeds T-1.

Optional Feature:
- Macro: GAME_SCREEN_PAUSE_EN.
- When defined:
  - pause_btn gets its own 2-flop synchronizer and edge detect.
  - In PLAY, a pause_pulse toggles an internal paused flag.
  - While paused: game_run=0, text_on=4'b0101 (title layer reused as a "PAUSED" banner, not blinking), and player_dead is ignored.
  - reset or leaving PLAY clears paused.
  - The screen code stays 2.
- When undefined:
  - pause_btn is unused and no pause logic is generated.
  - PLAY behaviour is exactly as specified above.

Test Plan:
- Bench parameters: FRAMES_PER_SEC=4, COUNT_START=3, BLINK_FRAMES=2, GAMEOVER_FRAMES=6; vsync pulses every 20 clk.
- Reset held 2 clk mid-PLAY -> next clk screen=0, timer=0, text_on=0001, game_run=0.
- In TITLE with no input, count frames -> text_on[0] toggles every 2 frame_ticks; exactly 1 frame_tick per vsync falling edge.
- start_btn held high 50 clk -> one transition to screen=1 and timer=3. timer steps 3->2->1 every 4 frames; at the 12th frame: screen=2, timer=0, game_run=1, text_on=0100.
- In PLAY, assert player_dead in the same clk as frame_tick -> next clk screen=3, game_run=0, text_on=1000. With no start press: after 6 frame_ticks, screen=0, text_on[0]=1.
- In GAMEOVER after 2 frames, start_btn pulse -> screen=0 three clk later; the frame counter restarts and no COUNTDOWN is entered from that same press.
- With GAME_SCREEN_PAUSE_EN defined, in PLAY: pause pulse -> game_run=0, text_on=0101; player_dead is ignored; a second pause pulse -> game_run=1, text_on=0100.
